// File: rtl/uart_tx_ctrl.sv
// Frame-level UART transmit sequencer: START, DATA (LSB first), optional PARITY, STOP, one bit per br_eq tick.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (sense set by PARITY_ODD).
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 br_eq,
  output logic                 tx_en,
  output logic                 br_en,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
      !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_bad_cfg
    $error("uart_tx_ctrl: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign tx_ready = (state == IDLE);
  assign br_en    = tx_en & br_eq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx_out    <= 1'b1;
      tx_en     <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg <= tx_data;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx_out    <= 1'b0;
            tx_en     <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
`ifdef UART_TX_PARITY_EN
            // Parity is taken from the byte as latched; the shift register is consumed by then.
            par_bit   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: begin
          if (br_eq) begin
            tx_out <= shift_reg[0];
            state  <= DATA;
          end
        end
        DATA: begin
          if (br_eq) begin
            shift_reg <= shift_reg >> 1;
            // bit_cnt holds at the last index so it never wraps inside a frame.
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_out <= par_bit;
              state  <= PARITY;
`else
              tx_out <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (br_eq) begin
            tx_out <= 1'b1;
            state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (br_eq) begin
            if (stop_cnt == LAST_STOP) begin
              tx_done <= 1'b1;
              tx_en   <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx_out <= 1'b1;
          tx_en  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: three instances (8-1 stop, 8-2 stop, odd parity sense), each with a
// divide-by-two baud tick model gated by its own tx_en.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
  localparam logic [63:0] A5_EXP = 64'h0CC333;
  localparam int          A5_LEN = 22;
`else
  localparam bit          PAR_EN = 1'b0;
  localparam logic [63:0] A5_EXP = 64'h330CF;
  localparam int          A5_LEN = 20;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       valid;
  logic [7:0] data;
  logic       br_kick;
  logic [1:0] sel;

  logic [2:0] vld, rdy, beq, ten, ben, txo, bsy, don;
  bit   [2:0] bcnt;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  assign vld[0] = valid && (sel == 2'd0);
  assign vld[1] = valid && (sel == 2'd1);
  assign vld[2] = valid && (sel == 2'd2);
  assign beq    = (ten & bcnt) | {3{br_kick}};

  always @(posedge clk) bcnt <= ten & ~bcnt;

  uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .reset(reset), .tx_valid(vld[0]), .tx_data(data), .tx_ready(rdy[0]),
    .br_eq(beq[0]), .tx_en(ten[0]), .br_en(ben[0]), .tx_out(txo[0]), .busy(bsy[0]), .tx_done(don[0]));
  uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(reset), .tx_valid(vld[1]), .tx_data(data), .tx_ready(rdy[1]),
    .br_eq(beq[1]), .tx_en(ten[1]), .br_en(ben[1]), .tx_out(txo[1]), .busy(bsy[1]), .tx_done(don[1]));
  uart_tx_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .reset(reset), .tx_valid(vld[2]), .tx_data(data), .tx_ready(rdy[2]),
    .br_eq(beq[2]), .tx_en(ten[2]), .br_en(ben[2]), .tx_out(txo[2]), .busy(bsy[2]), .tx_done(don[2]));

  logic m_rdy, m_txo, m_bsy, m_don, m_ben;
  assign m_rdy = rdy[sel];
  assign m_txo = txo[sel];
  assign m_bsy = bsy[sel];
  assign m_don = don[sel];
  assign m_ben = ben[sel];

  // Line capture of the selected instance: one sample per cycle while busy, newest in bit 0.
  logic [63:0] cap = '0;
  int cap_len = 0, done_cnt = 0, ben_cnt = 0, rdy_viol = 0;
  always @(negedge clk) begin
    if (m_bsy) begin
      cap = {cap[62:0], m_txo};
      cap_len++;
    end
    if (m_don) done_cnt++;
    if (m_ben) ben_cnt++;
    if (m_bsy && m_rdy) rdy_viol++;
  end

  function automatic logic [63:0] exp_frame(input logic [7:0] d, input int stops, input bit odd,
                                            output int len);
    logic [63:0] v;
    v = {v[61:0], 2'b00};
    v = '0;
    v = {v[61:0], 2'b00};
    for (int i = 0; i < 8; i++) v = {v[61:0], {2{d[i]}}};
    if (PAR_EN) v = {v[61:0], {2{(^d) ^ odd}}};
    for (int s = 0; s < stops; s++) v = {v[61:0], 2'b11};
    len = 2 * (1 + 8 + (PAR_EN ? 1 : 0) + stops);
    return v;
  endfunction

  function automatic logic [63:0] mask(input int len);
    return (64'd1 << len) - 64'd1;
  endfunction

  task automatic start_frame(input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    sel   = s;
    data  = d;
    valid = 1'b1;
    for (int i = 0; i < 50 && !m_rdy; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_don) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; valid = 1'b0; data = 8'h00; br_kick = 1'b0; sel = 2'd0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({txo, rdy, ten, bsy, don} !== 15'b111_111_000_000_000) begin
      fails++;
      $display("FAIL reset_hold: txo=%b rdy=%b ten=%b bsy=%b don=%b, want 111 111 000 000 000",
               txo, rdy, ten, bsy, don);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      br_kick = (i == 3 || i == 4);
      @(negedge clk);
      asserts++;
      if (txo !== 3'b111 || rdy !== 3'b111 || ten !== 3'b000 || bsy !== 3'b000 ||
          ben !== 3'b000 || don !== 3'b000) begin
        fails++;
        $display("FAIL idle_cycle%0d: txo=%b rdy=%b ten=%b bsy=%b ben=%b don=%b, want 111 111 000 000 000 000",
                 i, txo, rdy, ten, bsy, ben, don);
      end
    end
    br_kick = 1'b0;
  endtask

  task automatic test_frame_a5;
    int l0, d0, b0;
    bit ok;
    l0 = cap_len; d0 = done_cnt; b0 = ben_cnt;
    start_frame(2'd0, 8'hA5);
    wait_done(ok);
    asserts++;
    if (!ok) begin fails++; $display("FAIL a5_timeout: no tx_done within 100 cycles, want one"); end
    asserts++;
    if ((cap & mask(A5_LEN)) !== A5_EXP) begin
      fails++;
      $display("FAIL a5_line: got %h, want %h", cap & mask(A5_LEN), A5_EXP);
    end
    asserts++;
    if (cap_len - l0 !== A5_LEN) begin
      fails++; $display("FAIL a5_busy_len: got %0d cycles, want %0d", cap_len - l0, A5_LEN);
    end
    asserts++;
    if (done_cnt - d0 !== 1) begin
      fails++; $display("FAIL a5_done_count: got %0d, want 1", done_cnt - d0);
    end
    asserts++;
    if (ben_cnt - b0 !== A5_LEN / 2) begin
      fails++; $display("FAIL a5_br_en_count: got %0d, want %0d", ben_cnt - b0, A5_LEN / 2);
    end
    asserts++;
    if (m_rdy !== 1'b1 || m_txo !== 1'b1 || ten[0] !== 1'b0) begin
      fails++; $display("FAIL a5_end_idle: rdy=%b txo=%b ten=%b, want 1 1 0", m_rdy, m_txo, ten[0]);
    end
  endtask

  task automatic test_parity;
    logic [63:0] e;
    logic [1:0]  want_par;
    int l0, len;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      l0 = cap_len;
      start_frame(k == 0 ? 2'd0 : 2'd2, 8'h07);
      wait_done(ok);
      e = exp_frame(8'h07, 1, k == 1, len);
      asserts++;
      if (!ok || (cap & mask(len)) !== e) begin
        fails++;
        $display("FAIL parity_line%0d: got %h (done=%b), want %h", k, cap & mask(len), ok, e);
      end
      asserts++;
      if (cap_len - l0 !== len) begin
        fails++; $display("FAIL parity_len%0d: got %0d, want %0d", k, cap_len - l0, len);
      end
      // Bit pair just before the stop bit: parity when enabled, otherwise data bit 7 of 0x07.
      want_par = PAR_EN ? (k == 0 ? 2'b11 : 2'b00) : 2'b00;
      asserts++;
      if (cap[3:2] !== want_par) begin
        fails++; $display("FAIL parity_bit%0d: got %b, want %b", k, cap[3:2], want_par);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e1, e2;
    int l0, d0, v0, len;
    bit ok;
    e1 = exp_frame(8'h55, 1, 1'b0, len);
    e2 = exp_frame(8'hAA, 1, 1'b0, len);
    l0 = cap_len; d0 = done_cnt; v0 = rdy_viol;
    @(negedge clk);
    sel = 2'd0; data = 8'h55; valid = 1'b1;
    for (int i = 0; i < 50 && !m_rdy; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    data = 8'hAA;
    wait_done(ok);
    asserts++;
    if (!ok || m_bsy !== 1'b0 || m_txo !== 1'b1 || m_rdy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_gap: done=%b busy=%b txo=%b rdy=%b, want 1 0 1 1", ok, m_bsy, m_txo, m_rdy);
    end
    asserts++;
    if (rdy_viol !== v0) begin
      fails++; $display("FAIL b2b_ready_low: ready high on %0d busy cycles, want 0", rdy_viol - v0);
    end
    @(negedge clk);
    valid = 1'b0;
    asserts++;
    if (m_bsy !== 1'b1 || m_txo !== 1'b0) begin
      fails++; $display("FAIL b2b_restart: busy=%b txo=%b, want 1 0", m_bsy, m_txo);
    end
    wait_done(ok);
    asserts++;
    if (!ok || (cap & mask(2 * len)) !== ((e1 << len) | e2)) begin
      fails++;
      $display("FAIL b2b_line: got %h (done=%b), want %h", cap & mask(2 * len), ok, (e1 << len) | e2);
    end
    asserts++;
    if (cap_len - l0 !== 2 * len || done_cnt - d0 !== 2) begin
      fails++;
      $display("FAIL b2b_counts: busy=%0d done=%0d, want %0d 2", cap_len - l0, done_cnt - d0, 2 * len);
    end
  endtask

  task automatic test_stop_bits;
    logic [63:0] e;
    int l0, d0, len;
    bit ok;
    l0 = cap_len; d0 = done_cnt;
    start_frame(2'd1, 8'hFF);
    wait_done(ok);
    e = exp_frame(8'hFF, 2, 1'b0, len);
    asserts++;
    if (!ok || (cap & mask(len)) !== e) begin
      fails++; $display("FAIL stop2_line: got %h (done=%b), want %h", cap & mask(len), ok, e);
    end
    asserts++;
    if (cap_len - l0 !== len) begin
      fails++; $display("FAIL stop2_len: got %0d, want %0d", cap_len - l0, len);
    end
    asserts++;
    if (done_cnt - d0 !== 1) begin
      fails++; $display("FAIL stop2_done_count: got %0d, want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] e;
    int l0, len;
    bit ok;
    start_frame(2'd0, 8'hA5);
    repeat (8) @(posedge clk);
    #3;
    asserts++;
    if (m_bsy !== 1'b1 || m_txo !== 1'b0) begin
      fails++; $display("FAIL mid_bit3: busy=%b txo=%b, want 1 0", m_bsy, m_txo);
    end
    reset = 1'b0;
    #1;
    asserts++;
    if (txo[0] !== 1'b1 || ten[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1 || ben[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_async_reset: txo=%b ten=%b busy=%b rdy=%b ben=%b, want 1 0 0 1 0",
               txo[0], ten[0], bsy[0], rdy[0], ben[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    l0 = cap_len;
    start_frame(2'd0, 8'h3C);
    wait_done(ok);
    e = exp_frame(8'h3C, 1, 1'b0, len);
    asserts++;
    if (!ok || (cap & mask(len)) !== e || cap_len - l0 !== len) begin
      fails++;
      $display("FAIL mid_recover: got %h len %0d (done=%b), want %h len %0d",
               cap & mask(len), cap_len - l0, ok, e, len);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity();
    test_back_to_back();
    test_stop_bits();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
